// File: rtl/memory_request_arbiter_if.sv
// Client/injector bus for memory_request_arbiter. "slave" is the arbiter's view;
// "master" is the environment side (tile clients plus the latency injector).
interface memory_request_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int SIZE_WIDTH = 16
);
  logic [NUM_REQ-1:0]            cli_req_valid;
  logic [NUM_REQ-1:0]            cli_req_is_dram;
  logic [NUM_REQ*SIZE_WIDTH-1:0] cli_req_size_bytes;
  logic [NUM_REQ-1:0]            cli_req_ready;
  logic [NUM_REQ-1:0]            cli_resp_valid;
  logic [SIZE_WIDTH-1:0]         cli_resp_size_bytes;

  logic                  mem_req_valid;
  logic                  mem_req_is_dram;
  logic [SIZE_WIDTH-1:0] mem_req_size_bytes;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [SIZE_WIDTH-1:0] mem_resp_size_bytes;

  modport slave (
    input  cli_req_valid, cli_req_is_dram, cli_req_size_bytes,
    output cli_req_ready, cli_resp_valid, cli_resp_size_bytes,
    output mem_req_valid, mem_req_is_dram, mem_req_size_bytes,
    input  mem_req_ready, mem_resp_valid, mem_resp_size_bytes
  );

  modport master (
    output cli_req_valid, cli_req_is_dram, cli_req_size_bytes,
    input  cli_req_ready, cli_resp_valid, cli_resp_size_bytes,
    input  mem_req_valid, mem_req_is_dram, mem_req_size_bytes,
    output mem_req_ready, mem_resp_valid, mem_resp_size_bytes
  );
endinterface

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter sharing one injector port among NUM_REQ clients, with an in-order
// tag FIFO for response steering. Define MEM_ARB_REQ0_PRIORITY_EN to give client 0 strict priority.
module memory_request_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SIZE_WIDTH      = 16,
  parameter int TAG_FIFO_DEPTH  = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  memory_request_arbiter_if.slave           bus,
  output logic [32*NUM_REQ-1:0]             grant_cnt,
  output logic [$clog2(TAG_FIFO_DEPTH):0]   tag_level,
  output logic                              resp_orphan_err,
  output logic                              busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [ID_W-1:0] id_t;
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state, state_next;
  id_t                    rr_ptr, grant_id, req_id, pop_id;
  logic                   grant_any, handshake, push, pop, orphan;
  logic                   req_is_dram;
  logic [SIZE_WIDTH-1:0]  req_size, resp_size;
  logic [NUM_REQ-1:0]     eligible, ready_vec, resp_valid;
  logic [OUT_W-1:0]       outstanding [NUM_REQ];
  logic [31:0]            grant_q     [NUM_REQ];
  id_t                    tag_mem     [TAG_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.cli_req_valid[i]
                 && (outstanding[i] < OUT_W'(MAX_OUTSTANDING))
                 && (tag_level < LVL_W'(TAG_FIFO_DEPTH));
    end
  end

  // First eligible client at or after rr_ptr, wrapping.
  always_comb begin
    id_t idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
`ifdef MEM_ARB_REQ0_PRIORITY_EN
    if (eligible[0]) begin
      grant_any = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = id_t'(1 + (((rr_ptr == '0 ? 1 : int'(rr_ptr)) - 1 + k) % (NUM_REQ - 1)));
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          grant_id  = idx;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = id_t'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
`endif
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    ready_vec  = '0;
    handshake  = 1'b0;
    push       = 1'b0;
    if (state == IDLE) begin
      if (grant_any && reset_n) begin
        ready_vec[grant_id] = 1'b1;
        handshake           = 1'b1;
        state_next          = ISSUE;
      end
    end else if (bus.mem_req_ready) begin
      push       = 1'b1;
      state_next = IDLE;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  assign pop    = bus.mem_resp_valid && (tag_level != '0);
  assign orphan = bus.mem_resp_valid && (tag_level == '0);
  assign pop_id = tag_mem[rd_ptr];

  // NOTE: the tag storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= req_id;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr          <= '0;
      req_id          <= '0;
      req_is_dram     <= 1'b0;
      req_size        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_level       <= '0;
      resp_valid      <= '0;
      resp_size       <= '0;
      resp_orphan_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outstanding[i] <= '0;
        grant_q[i]     <= '0;
      end
    end else begin
      if (handshake) begin
        req_id      <= grant_id;
        req_is_dram <= bus.cli_req_is_dram[grant_id];
        req_size    <= bus.cli_req_size_bytes[int'(grant_id)*SIZE_WIDTH +: SIZE_WIDTH];
      end

      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(TAG_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
`ifdef MEM_ARB_REQ0_PRIORITY_EN
        if (req_id != '0)
          rr_ptr <= (req_id == id_t'(NUM_REQ - 1)) ? id_t'(1) : req_id + 1'b1;
`else
        rr_ptr <= (req_id == id_t'(NUM_REQ - 1)) ? '0 : req_id + 1'b1;
`endif
      end

      if (pop) begin
        rd_ptr    <= (rd_ptr == PTR_W'(TAG_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        resp_size <= bus.mem_resp_size_bytes;
      end
      resp_valid <= pop ? (NUM_REQ'(1) << pop_id) : '0;

      if (push && !pop)      tag_level <= tag_level + 1'b1;
      else if (pop && !push) tag_level <= tag_level - 1'b1;

      if (orphan) resp_orphan_err <= 1'b1;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (push && req_id == id_t'(i)) grant_q[i] <= grant_q[i] + 1'b1;
        if ((push && req_id == id_t'(i)) && !(pop && pop_id == id_t'(i)))
          outstanding[i] <= outstanding[i] + 1'b1;
        else if ((pop && pop_id == id_t'(i)) && !(push && req_id == id_t'(i)))
          outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*32 +: 32] = grant_q[i];
  end

  assign bus.cli_req_ready       = ready_vec;
  assign bus.cli_resp_valid      = resp_valid;
  assign bus.cli_resp_size_bytes = resp_size;
  assign bus.mem_req_valid       = (state == ISSUE);
  assign bus.mem_req_is_dram     = req_is_dram;
  assign bus.mem_req_size_bytes  = req_size;
  assign busy                    = (state == ISSUE) || (tag_level != '0);
endmodule

// File: tb/tb_memory_request_arbiter.sv
// Self-checking bench for memory_request_arbiter: queue-based transaction model compared
// every cycle, a small latency-injector model, and directed scenarios with literal expectations.
module tb_memory_request_arbiter;
  localparam int N = 4, SW = 16, DEPTH = 8, MAXO = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  memory_request_arbiter_if #(.NUM_REQ(N), .SIZE_WIDTH(SW)) bus ();
  logic [32*N-1:0]          grant_cnt;
  logic [$clog2(DEPTH):0]   tag_level;
  logic                     resp_orphan_err, busy;

  memory_request_arbiter #(
    .NUM_REQ(N), .SIZE_WIDTH(SW), .TAG_FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .grant_cnt(grant_cnt), .tag_level(tag_level),
    .resp_orphan_err(resp_orphan_err), .busy(busy)
  );

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_issue, cmp_en = 1'b0;
  int              m_id, m_rr;
  bit              m_dram, m_orphan;
  logic [SW-1:0]   m_size, m_resp_size;
  logic [N-1:0]    m_resp;
  int              m_tags[$];
  int              m_out[N];
  int unsigned     m_cnt[N];
  int              grant_log[$], grant_resp_seen[$], resp_log[$];

  function automatic bit elig(int c);
    return bus.cli_req_valid[c] && m_out[c] < MAXO && m_tags.size() < DEPTH;
  endfunction

  function automatic int pick();
    int s;
    if (!reset_n || m_issue) return -1;
`ifdef MEM_ARB_REQ0_PRIORITY_EN
    if (elig(0)) return 0;
    s = (m_rr == 0) ? 1 : m_rr;
    for (int k = 0; k < N - 1; k++) if (elig(1 + ((s - 1 + k) % (N - 1)))) return 1 + ((s - 1 + k) % (N - 1));
`else
    s = m_rr;
    for (int k = 0; k < N; k++) if (elig((s + k) % N)) return (s + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, p;
    logic [N-1:0] rv;
    // observation logs for the directed scenarios (pre-edge DUT values)
    if (reset_n) begin
      for (int i = 0; i < N; i++) if (bus.cli_resp_valid[i]) resp_log.push_back(i);
      for (int i = 0; i < N; i++)
        if (bus.cli_req_ready[i] && bus.cli_req_valid[i]) begin
          grant_log.push_back(i);
          grant_resp_seen.push_back(resp_log.size());
        end
    end
    g = pick();
    if (!reset_n) begin
      m_issue = 0; m_rr = 0; m_orphan = 0; m_resp = '0; m_resp_size = '0;
      m_tags.delete();
      for (int i = 0; i < N; i++) begin m_out[i] = 0; m_cnt[i] = 0; end
      cmp_en = 1'b1;
    end else begin
      rv = '0;
      if (bus.mem_resp_valid) begin
        if (m_tags.size() > 0) begin
          p = m_tags.pop_front();
          m_out[p]--;
          rv[p] = 1'b1;
          m_resp_size = bus.mem_resp_size_bytes;
        end else m_orphan = 1'b1;
      end
      m_resp = rv;
      if (g >= 0) begin
        m_issue = 1; m_id = g;
        m_dram  = bus.cli_req_is_dram[g];
        m_size  = bus.cli_req_size_bytes[g*SW +: SW];
      end else if (m_issue && bus.mem_req_ready) begin
        m_tags.push_back(m_id);
        m_out[m_id]++;
        m_cnt[m_id]++;
`ifdef MEM_ARB_REQ0_PRIORITY_EN
        if (m_id != 0) m_rr = ((m_id + 1) % N == 0) ? 1 : m_id + 1;
`else
        m_rr = (m_id + 1) % N;
`endif
        m_issue = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (cmp_en) begin
      g = pick();
      check("cli_req_ready", bus.cli_req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      check("mem_req_valid", bus.mem_req_valid, m_issue);
      if (m_issue) begin
        check("mem_req_is_dram", bus.mem_req_is_dram, m_dram);
        check("mem_req_size", bus.mem_req_size_bytes, m_size);
      end
      check("cli_resp_valid", bus.cli_resp_valid, m_resp);
      if (m_resp != '0) check("cli_resp_size", bus.cli_resp_size_bytes, m_resp_size);
      check("tag_level", tag_level, m_tags.size());
      check("resp_orphan_err", resp_orphan_err, m_orphan);
      check("busy", busy, m_issue || m_tags.size() != 0);
      for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*32 +: 32], m_cnt[i]);
    end
  end

  // ---------------- injector model ----------------
  typedef struct { int due; logic [SW-1:0] size; } inj_t;
  inj_t inj_q[$];
  int   cyc = 0, inj_lat = 2, orphan_req = 0, orphan_done = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) inj_q.delete();
    else if (bus.mem_req_valid && bus.mem_req_ready)
      inj_q.push_back('{due: cyc + inj_lat, size: bus.mem_req_size_bytes});
    #2;
    bus.mem_resp_valid      = 1'b0;
    bus.mem_resp_size_bytes = '0;
    if (orphan_req != orphan_done) begin
      bus.mem_resp_valid      = 1'b1;
      bus.mem_resp_size_bytes = 16'hdead;
      orphan_done++;
    end else if (inj_q.size() > 0 && inj_q[0].due <= cyc) begin
      bus.mem_resp_valid      = 1'b1;
      bus.mem_resp_size_bytes = inj_q[0].size;
      void'(inj_q.pop_front());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.cli_req_valid = '0;
    tick(2);
    reset_n = 1'b1;
    grant_log.delete(); grant_resp_seen.delete(); resp_log.delete();
  endtask

  task automatic set_client(input int c, input bit v, input bit dram, input logic [SW-1:0] size);
    bus.cli_req_valid[c]               = v;
    bus.cli_req_is_dram[c]             = dram;
    bus.cli_req_size_bytes[c*SW +: SW] = size;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin tick(); k++; end
    check("grant_budget", grant_log.size() >= n, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cli_req_valid = '0; bus.cli_req_is_dram = '0; bus.cli_req_size_bytes = '0;
    bus.mem_req_ready = 1'b1;
    tick(1);
    do_reset();

    // reset values
    check("rst_ready", bus.cli_req_ready, 0);
    check("rst_mem_valid", bus.mem_req_valid, 0);
    check("rst_tag_level", tag_level, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_cnt", grant_cnt[63:0], 0);
    check("rst_orphan", resp_orphan_err, 0);

    // single request from client 2
    inj_lat = 2;
    set_client(2, 1, 0, 16'd64);
    wait_grants(1, 20);
    set_client(2, 0, 0, 16'd64);
    check("t1_grantee", grant_log[0], 2);
    check("t1_mem_valid", bus.mem_req_valid, 1);
    check("t1_mem_size", bus.mem_req_size_bytes, 64);
    check("t1_mem_dram", bus.mem_req_is_dram, 0);
    tick(10);
    check("t1_resp_count", resp_log.size(), 1);
    check("t1_grant_cnt2", grant_cnt[2*32 +: 32], 1);
    check("t1_tag_level", tag_level, 0);

    // all clients continuously valid, zero latency
    do_reset();
    inj_lat = 0;
    for (int i = 0; i < N; i++) set_client(i, 1, i[0], SW'(16 * i + 8));
    wait_grants(12, 100);
    bus.cli_req_valid = '0;
    for (int k = 0; k < 12; k++) check("t2_order", grant_log[k], k % 4);
    tick(10);
    for (int i = 0; i < N; i++) check("t2_grant_cnt", grant_cnt[i*32 +: 32], 3);

    // outstanding cap for client 1
    do_reset();
    inj_lat = 30;
    set_client(1, 1, 1, 16'd128);
    wait_grants(4, 40);
    tick(4);
    check("t3_tag_level", tag_level, 4);
    check("t3_ready_blocked", bus.cli_req_ready, 0);
    check("t3_no_resp_yet", grant_resp_seen[3], 0);
    wait_grants(5, 80);
    check("t3_fifth_after_resp", grant_resp_seen[4] >= 1, 1);
    bus.cli_req_valid = '0;
    tick(60);
    check("t3_drained", tag_level, 0);

    // injector stall while in ISSUE
    do_reset();
    inj_lat = 2;
    bus.mem_req_ready = 1'b0;
    set_client(3, 1, 1, 16'h1234);
    wait_grants(1, 20);
    bus.cli_req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_hold_valid", bus.mem_req_valid, 1);
      check("t4_hold_size", bus.mem_req_size_bytes, 16'h1234);
      check("t4_hold_dram", bus.mem_req_is_dram, 1);
      check("t4_no_push", tag_level, 0);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    check("t4_issue_done", bus.mem_req_valid, 0);
    check("t4_pushed", tag_level, 1);
    check("t4_grant_cnt3", grant_cnt[3*32 +: 32], 1);
    tick(10);

    // orphan response
    do_reset();
    orphan_req++;
    tick(3);
    check("t5_orphan_set", resp_orphan_err, 1);
    check("t5_no_pulse", resp_log.size(), 0);
    tick(5);
    check("t5_orphan_sticky", resp_orphan_err, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_orphan_cleared", resp_orphan_err, 0);

`ifdef MEM_ARB_REQ0_PRIORITY_EN
    do_reset();
    inj_lat = 30;
    set_client(0, 1, 0, 16'd32);
    set_client(3, 1, 1, 16'd48);
    wait_grants(5, 60);
    bus.cli_req_valid = '0;
    for (int k = 0; k < 4; k++) check("t6_req0_first", grant_log[k], 0);
    check("t6_then_3", grant_log[4], 3);
    tick(60);
`endif

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_request_arbiter.md
# memory_request_arbiter

Shares one `memory_latency_injector` request/response port between `NUM_REQ` tile clients (DMA, weight fetch, activation spill). The arbiter picks one client with a round-robin grant and forwards its request to the injector through a registered issue stage. It records the grantee ID in an in-order tag FIFO, then steers each injector response back to the client that issued it. A per-client outstanding limit stops any one client from filling the injector queue.

## Interface
- `NUM_REQ`, 4: number of clients (2..8).
- `SIZE_WIDTH`, 16: request/response size field width; must match the injector.
- `TAG_FIFO_DEPTH`, 8: in-flight request capacity; must be >= injector `QUEUE_DEPTH`+1.
- `MAX_OUTSTANDING`, 4: per-client in-flight cap (1..TAG_FIFO_DEPTH).
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cli_req_valid` in NUM_REQ: per-client request valid.
- `cli_req_is_dram` in NUM_REQ: per-client target; 0=SRAM, 1=DRAM.
- `cli_req_size_bytes` in NUM_REQ*SIZE_WIDTH: flattened sizes; client i uses bits [i*SIZE_WIDTH +: SIZE_WIDTH].
- `cli_req_ready` out NUM_REQ: one-hot grant (zero or one bit set).
- `cli_resp_valid` out NUM_REQ: one-hot, one-cycle response pulse.
- `cli_resp_size_bytes` out SIZE_WIDTH: shared response size, valid with `cli_resp_valid`.
- `mem_req_valid` out 1: request to the injector.
- `mem_req_is_dram` out 1: forwarded target.
- `mem_req_size_bytes` out SIZE_WIDTH: forwarded size.
- `mem_req_ready` in 1: injector accept.
- `mem_resp_valid` in 1: injector response pulse.
- `mem_resp_size_bytes` in SIZE_WIDTH: injector response size.
- `grant_cnt` out 32*NUM_REQ: per-client count of issued requests, flattened.
- `tag_level` out $clog2(TAG_FIFO_DEPTH)+1: number of requests in flight.
- `resp_orphan_err` out 1: sticky; set when a response arrives while the tag FIFO is empty.
- `busy` out 1: high when in ISSUE state or `tag_level`!=0.

## Operation
- Client i is eligible when all of these hold:
  - `cli_req_valid[i]`
  - `outstanding[i] < MAX_OUTSTANDING`
  - `tag_level < TAG_FIFO_DEPTH`
- **IDLE state:**
  - `cli_req_ready` is asserted combinationally for the first eligible client, searching from `rr_ptr` upward with wrap.
  - On the handshake the arbiter latches `is_dram`, `size` and the grantee ID, then moves to ISSUE.
  - If no client is eligible, `cli_req_ready` stays 0.
- **ISSUE state:**
  - `mem_req_*` is driven from the latched registers and `cli_req_ready` is 0.
  - When `mem_req_ready` is high, the arbiter pushes the ID into the tag FIFO, increments `outstanding[ID]` and `grant_cnt[ID]`, sets `rr_ptr` to (ID+1) mod NUM_REQ, and returns to IDLE.
- **Response path:**
  - On `mem_resp_valid` with a non-empty FIFO, the arbiter pops the head ID.
  - On the next edge, `cli_resp_valid[ID]` pulses, `cli_resp_size_bytes` takes `mem_resp_size_bytes`, and `outstanding[ID]` decrements.
  - On `mem_resp_valid` with an empty FIFO, `resp_orphan_err` is set, nothing is popped, and no client pulse is generated.
- **Boundary cases:**
  - Push and pop in the same cycle: `tag_level` is unchanged. If both belong to the same client, `outstanding` is unchanged.
  - The tag FIFO pointers wrap modulo TAG_FIFO_DEPTH.
  - `grant_cnt` wraps at 2^32.
  - `outstanding` counters are $clog2(MAX_OUTSTANDING+1) bits wide and never under- or overflow, because eligibility gates increments and pops gate decrements.
- **Reset mid-operation:** all state clears and any latched request is dropped. The injector must be reset in the same cycle; otherwise its stale responses are flagged as orphans.

## Timing
- Reset values:
  - all outputs 0 (including `resp_orphan_err`, `grant_cnt`, `tag_level`, `busy`)
  - state IDLE
  - `rr_ptr` 0
- Client request handshake at edge T gives `mem_req_valid` from T+1 until the edge where `mem_req_ready` is sampled high.
- Issue throughput is at most one request per 2 cycles: the IDLE cycle followed by the ISSUE cycle.
- Injector response at edge R gives the client pulse at R+1, a fixed 1-cycle response latency.
- `mem_req_*` fields are stable while `mem_req_valid` is high and `mem_req_ready` is low.

## Configuration
- `MEM_ARB_REQ0_PRIORITY_EN` defined:
  - In IDLE, client 0 wins whenever it is eligible.
  - Round-robin applies only among clients 1..NUM_REQ-1; `rr_ptr` skips 0 and is updated only by grants to non-zero clients.
- `MEM_ARB_REQ0_PRIORITY_EN` undefined: pure round-robin over all clients, as described above.

## Test plan
- Reset, then client 2 requests once (SRAM, size 64) with `mem_req_ready`=1 and injector latency 2 -> `mem_req_valid` at T+1 with size 64 and is_dram 0, `cli_resp_valid[2]` pulses once, `grant_cnt[2]`=1, `tag_level` returns to 0.
- All 4 clients hold valid continuously, with `mem_req_ready`=1 and injector SRAM latency 0 -> grant order 0,1,2,3,0,1,...; each `grant_cnt` is 3 after 12 grants.
- Client 1 alone, with MAX_OUTSTANDING=4 and DRAM latency 30 -> exactly 4 issues, then `cli_req_ready[1]`=0 until the first response, then a 5th issue.
- Injector QUEUE_DEPTH=8, `mem_req_ready` forced low for 10 cycles while in ISSUE -> `mem_req_*` is held constant and there is no FIFO push; the issue completes on the cycle ready rises.
- Inject `mem_resp_valid` with FIFO empty -> `resp_orphan_err`=1 and stays 1, with no `cli_resp_valid` pulse; assert `reset_n`=0 for 1 cycle -> `resp_orphan_err` returns to 0.
- With `MEM_ARB_REQ0_PRIORITY_EN` and clients 0 and 3 always valid -> client 0 receives every grant until it hits MAX_OUTSTANDING, then client 3 is granted.
